// File: rtl/catc_fetch_stall.sv
// catc_fetch_stall: single-line read buffer between a clock-enable gated
// retro core and slow burst memory. A hit is answered on the cycle after the
// request. A miss raises Delay so the CATC generator freezes the core while
// the whole line is burst in. The block also records how long each stall
// lasted and keeps a sticky flag for stalls that grew too long.
module catc_fetch_stall #(
    parameter int AddrWidth = 24,
    parameter int DataWidth = 8,
    parameter int LineWords = 8,
    parameter int MaxDelay  = 4095
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 CoreCe,
    input  logic                 CoreReq,
    input  logic [AddrWidth-1:0] CoreAddr,
    output logic [DataWidth-1:0] CoreData,
    output logic                 CoreValid,
    output logic                 Delay,
    output logic                 MemReq,
    output logic [AddrWidth-1:0] MemAddr,
    input  logic                 MemReady,
    input  logic                 MemRdValid,
    input  logic [DataWidth-1:0] MemRdData,
    input  logic                 Flush,
    output logic                 Error,
    output logic [15:0]          DelayCycles
);

    localparam int OffWidth = $clog2(LineWords);
    localparam int TagWidth = AddrWidth - OffWidth;
    localparam logic [OffWidth-1:0] LastBeat = OffWidth'(LineWords - 1);
    localparam logic [15:0] MaxCount = 16'(MaxDelay);
    localparam logic [15:0] CountSat = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL_REQ  = 2'd1,
        FILL_DATA = 2'd2,
        DONE      = 2'd3
    } stateT;

    stateT state;
    stateT stateNext;

    // Line storage and its bookkeeping
    logic [DataWidth-1:0] lineMem [LineWords];
    logic [TagWidth-1:0]  lineTag;
    logic                 lineValid;
    logic                 flushPending;

    // Miss context held for the duration of a fill
    logic [TagWidth-1:0]  reqTag;
    logic [OffWidth-1:0]  reqOffset;
    logic [OffWidth-1:0]  beat;

    // Stall length measurement
    logic [15:0]          stallCount;

    // Request decode
    logic [OffWidth-1:0]  coreOffset;
    logic [TagWidth-1:0]  coreTag;
    logic                 sampleReq;
    logic                 tagHit;
    logic                 isHit;
    logic                 isMiss;
    logic                 memAccept;
    logic                 beatWrite;
    logic                 lastBeat;
    logic                 fillNext;

    assign coreOffset = CoreAddr[OffWidth-1:0];
    assign coreTag    = CoreAddr[AddrWidth-1:OffWidth];

    // Requests are only looked at in IDLE; the core is frozen during a fill
    // anyway, so anything arriving then is stray and dropped.
    assign sampleReq  = (state == IDLE) && CoreCe && CoreReq;
    assign tagHit     = lineValid && (coreTag == lineTag);
    assign isHit      = sampleReq && tagHit;
    assign isMiss     = sampleReq && !tagHit;
    assign memAccept  = (state == FILL_REQ) && MemReq && MemReady;
    assign beatWrite  = (state == FILL_DATA) && MemRdValid;
    assign lastBeat   = beatWrite && (beat == LastBeat);
    assign fillNext   = (stateNext == FILL_REQ) || (stateNext == FILL_DATA);

    // FSM state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // FSM next-state decode
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (isMiss) begin
                    stateNext = FILL_REQ;
                end
            end
            FILL_REQ: begin
                if (memAccept) begin
                    stateNext = FILL_DATA;
                end
            end
            FILL_DATA: begin
                if (lastBeat) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Delay and the memory request are flopped from the next state so that
    // Delay never depends combinationally on CoreCe (CATC gates CE with it).
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Delay   <= 1'b0;
            MemReq  <= 1'b0;
            MemAddr <= '0;
        end else begin
            Delay  <= fillNext;
            MemReq <= (stateNext == FILL_REQ);
            if (isMiss) begin
                MemAddr <= {coreTag, {OffWidth{1'b0}}};
            end
        end
    end

    // Capture the missing address so the answer and new tag survive the fill
    always_ff @(posedge Clk) begin
        if (Reset) begin
            reqTag    <= '0;
            reqOffset <= '0;
        end else if (isMiss) begin
            reqTag    <= coreTag;
            reqOffset <= coreOffset;
        end
    end

    // Beat counter restarts when the burst is accepted
    always_ff @(posedge Clk) begin
        if (Reset) begin
            beat <= '0;
        end else if (memAccept) begin
            beat <= '0;
        end else if (beatWrite) begin
            beat <= beat + 1'b1;
        end
    end

    // Line data array; holds no reset since the valid bit guards it
    always_ff @(posedge Clk) begin
        if (!Reset && beatWrite) begin
            lineMem[beat] <= MemRdData;
        end
    end

    // Tag, valid and deferred-flush tracking. The line is invalidated as
    // soon as a fill starts because its contents are being overwritten.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            lineTag      <= '0;
            lineValid    <= 1'b0;
            flushPending <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (isMiss || Flush) begin
                        lineValid <= 1'b0;
                    end
                    if (isMiss) begin
                        flushPending <= 1'b0;
                    end
                end
                FILL_REQ, FILL_DATA: begin
                    if (Flush) begin
                        flushPending <= 1'b1;
                    end
                end
                DONE: begin
                    lineTag      <= reqTag;
                    lineValid    <= !(flushPending || Flush);
                    flushPending <= 1'b0;
                end
                default: begin
                    lineValid <= 1'b0;
                end
            endcase
        end
    end

    // Core response: hits answer next cycle; a fill answers on entry to
    // DONE, forwarding the final beat when it is the requested word.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            CoreValid <= 1'b0;
            CoreData  <= '0;
        end else begin
            CoreValid <= 1'b0;
            if (isHit) begin
                CoreValid <= 1'b1;
                CoreData  <= lineMem[coreOffset];
            end else if (lastBeat) begin
                CoreValid <= 1'b1;
                if (reqOffset == beat) begin
                    CoreData <= MemRdData;
                end else begin
                    CoreData <= lineMem[reqOffset];
                end
            end
        end
    end

    // Stall measurement: count Delay cycles, publish in DONE, and latch the
    // watchdog flag on the cycle the count reaches the limit.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stallCount  <= '0;
            DelayCycles <= '0;
            Error       <= 1'b0;
        end else begin
            if (isMiss) begin
                stallCount <= '0;
            end else if (Delay && (stallCount != CountSat)) begin
                stallCount <= stallCount + 16'd1;
            end
            if (Delay && (stallCount != CountSat) && ((stallCount + 16'd1) == MaxCount)) begin
                Error <= 1'b1;
            end
            if (state == DONE) begin
                DelayCycles <= stallCount;
            end
        end
    end

endmodule

// File: tb/tb_catc_fetch_stall.sv
// Bench for catc_fetch_stall: directed reads against a hand-driven burst
// memory. Expected core data is queued at request time and a monitor pops
// and compares it whenever CoreValid pulses.
module tb_catc_fetch_stall;

    localparam int AddrWidth = 24;
    localparam int DataWidth = 8;
    localparam int LineWords = 8;
    localparam int MaxDelay  = 16;

    logic                 Clk = 1'b0;
    logic                 Reset;
    logic                 coreCe;
    logic                 coreReq;
    logic [AddrWidth-1:0] coreAddr;
    logic [DataWidth-1:0] coreData;
    logic                 coreValid;
    logic                 delay;
    logic                 memReq;
    logic [AddrWidth-1:0] memAddr;
    logic                 memReady;
    logic                 memRdValid;
    logic [DataWidth-1:0] memRdData;
    logic                 flush;
    logic                 error;
    logic [15:0]          delayCycles;

    int checkCount = 0;
    int passCount = 0;
    int delayHighCount = 0;
    int delayMark = 0;
    logic [DataWidth-1:0] expQ [$];
    logic [DataWidth-1:0] monExp;

    catc_fetch_stall #(
        .AddrWidth (AddrWidth),
        .DataWidth (DataWidth),
        .LineWords (LineWords),
        .MaxDelay  (MaxDelay)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .CoreCe      (coreCe),
        .CoreReq     (coreReq),
        .CoreAddr    (coreAddr),
        .CoreData    (coreData),
        .CoreValid   (coreValid),
        .Delay       (delay),
        .MemReq      (memReq),
        .MemAddr     (memAddr),
        .MemReady    (memReady),
        .MemRdValid  (memRdValid),
        .MemRdData   (memRdData),
        .Flush       (flush),
        .Error       (error),
        .DelayCycles (delayCycles)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: tally Delay cycles and score every core response
    always @(negedge Clk) begin
        if (delay === 1'b1) begin
            delayHighCount++;
        end
        if (coreValid === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected CoreValid", 32'(coreValid), 32'd0);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("CoreData", 32'(coreData), 32'(monExp));
            end
        end
    end

    // One core tick with a read request; called on a negedge
    task automatic applyStimulus(input logic [AddrWidth-1:0] addr, input logic [DataWidth-1:0] expData,
                                 input bit expectResp, input bit withFlush);
        coreCe   = 1'b1;
        coreReq  = 1'b1;
        coreAddr = addr;
        flush    = withFlush;
        if (expectResp) begin
            expQ.push_back(expData);
        end
        @(negedge Clk);
        coreCe  = 1'b0;
        coreReq = 1'b0;
        flush   = 1'b0;
    endtask

    // Memory side of one fill. readyWait: cycles MemReq is held unanswered;
    // spacing: cycles from one beat to the next. Negative beat indices
    // disable the flush / reset / stray-request injections.
    task automatic serveFill(input logic [AddrWidth-1:0] expBase, input int readyWait, input int spacing,
                             input logic [DataWidth-1:0] startVal, input int flushBeat,
                             input int resetBeat, input int strayBeat, input bit chkErr);
        int waitCycles;
        waitCycles = 0;
        while (memReq !== 1'b1 && waitCycles < 40) begin
            @(negedge Clk);
            waitCycles++;
        end
        checkOutput("MemReq raised", 32'(memReq), 32'd1);
        if (memReq !== 1'b1) begin
            return;
        end
        checkOutput("MemAddr line base", 32'(memAddr), 32'(expBase));
        for (int w = 1; w <= readyWait; w++) begin
            if (chkErr && w == 15) begin
                checkOutput("Error before limit", 32'(error), 32'd0);
            end
            if (chkErr && w == 17) begin
                checkOutput("Error at limit", 32'(error), 32'd1);
            end
            @(negedge Clk);
        end
        memReady = 1'b1;
        @(negedge Clk);
        memReady = 1'b0;
        for (int i = 0; i < LineWords; i++) begin
            if (i > 0) begin
                repeat (spacing - 1) @(negedge Clk);
            end
            memRdValid = 1'b1;
            memRdData  = startVal + DataWidth'(i);
            if (i == flushBeat) begin
                flush = 1'b1;
            end
            if (i == strayBeat) begin
                coreCe   = 1'b1;
                coreReq  = 1'b1;
                coreAddr = 24'h000A05;
            end
            if (i == resetBeat) begin
                Reset = 1'b1;
            end
            @(negedge Clk);
            memRdValid = 1'b0;
            flush      = 1'b0;
            coreCe     = 1'b0;
            coreReq    = 1'b0;
            if (i == resetBeat) begin
                Reset = 1'b0;
                checkOutput("Delay after reset", 32'(delay), 32'd0);
                checkOutput("MemReq after reset", 32'(memReq), 32'd0);
                checkOutput("Error after reset", 32'(error), 32'd0);
                checkOutput("DelayCycles after reset", 32'(delayCycles), 32'd0);
            end
        end
        if (resetBeat < 0) begin
            checkOutput("CoreValid in DONE", 32'(coreValid), 32'd1);
            checkOutput("Delay low in DONE", 32'(delay), 32'd0);
            checkOutput("MemReq low in DONE", 32'(memReq), 32'd0);
        end
    endtask

    // Main directed sequence
    initial begin
        Reset      = 1'b1;
        coreCe     = 1'b0;
        coreReq    = 1'b0;
        coreAddr   = '0;
        memReady   = 1'b0;
        memRdValid = 1'b0;
        memRdData  = '0;
        flush      = 1'b0;
        repeat (3) @(negedge Clk);
        checkOutput("reset Delay", 32'(delay), 32'd0);
        checkOutput("reset MemReq", 32'(memReq), 32'd0);
        checkOutput("reset CoreValid", 32'(coreValid), 32'd0);
        checkOutput("reset CoreData", 32'(coreData), 32'd0);
        checkOutput("reset Error", 32'(error), 32'd0);
        checkOutput("reset DelayCycles", 32'(delayCycles), 32'd0);
        checkOutput("reset MemAddr", 32'(memAddr), 32'd0);
        Reset = 1'b0;
        @(negedge Clk);

        // Cold miss, fastest memory: 9 stall cycles
        delayMark = delayHighCount;
        applyStimulus(24'h000123, 8'h13, 1'b1, 1'b0);
        serveFill(24'h000120, 0, 1, 8'h10, -1, -1, -1, 1'b0);
        @(negedge Clk);
        checkOutput("cold DelayCycles", 32'(delayCycles), 32'd9);
        checkOutput("cold Delay cycles seen", 32'(delayHighCount - delayMark), 32'd9);
        checkOutput("cold Error", 32'(error), 32'd0);

        // Hit in the same line: next-cycle answer, no stall
        delayMark = delayHighCount;
        applyStimulus(24'h000125, 8'h15, 1'b1, 1'b0);
        checkOutput("hit CoreValid", 32'(coreValid), 32'd1);
        repeat (3) @(negedge Clk);
        checkOutput("hit Delay cycles seen", 32'(delayHighCount - delayMark), 32'd0);
        checkOutput("hit DelayCycles kept", 32'(delayCycles), 32'd9);

        // Hit with coincident flush answers from the old line, then misses
        applyStimulus(24'h000122, 8'h12, 1'b1, 1'b1);
        @(negedge Clk);
        applyStimulus(24'h000122, 8'h32, 1'b1, 1'b0);
        serveFill(24'h000120, 0, 1, 8'h30, -1, -1, -1, 1'b0);
        @(negedge Clk);

        // Flush during fill; offset 7 is answered from the final beat
        applyStimulus(24'h000457, 8'h47, 1'b1, 1'b0);
        serveFill(24'h000450, 0, 1, 8'h40, 3, -1, -1, 1'b0);
        @(negedge Clk);
        applyStimulus(24'h000452, 8'h62, 1'b1, 1'b0);
        serveFill(24'h000450, 0, 1, 8'h60, -1, -1, -1, 1'b0);
        @(negedge Clk);
        applyStimulus(24'h000450, 8'h60, 1'b1, 1'b0);
        checkOutput("refilled line hits", 32'(coreValid), 32'd1);
        @(negedge Clk);

        // Stray request while stalled must not disturb the fill
        applyStimulus(24'h000803, 8'h83, 1'b1, 1'b0);
        serveFill(24'h000800, 0, 1, 8'h80, -1, -1, 2, 1'b0);
        @(negedge Clk);
        checkOutput("stray MemAddr", 32'(memAddr), 32'h000800);
        checkOutput("stray DelayCycles", 32'(delayCycles), 32'd9);
        applyStimulus(24'h000801, 8'h81, 1'b1, 1'b0);
        checkOutput("stray line still hits", 32'(coreValid), 32'd1);
        @(negedge Clk);

        // Watchdog: MemReady withheld 20 cycles, 29-cycle stall
        delayMark = delayHighCount;
        applyStimulus(24'h000B06, 8'hB6, 1'b1, 1'b0);
        serveFill(24'h000B00, 20, 1, 8'hB0, -1, -1, -1, 1'b1);
        @(negedge Clk);
        checkOutput("watchdog DelayCycles", 32'(delayCycles), 32'd29);
        checkOutput("watchdog Delay cycles seen", 32'(delayHighCount - delayMark), 32'd29);
        checkOutput("watchdog Error held", 32'(error), 32'd1);

        // Backpressure: MemReady at T+5, beats every second cycle
        delayMark = delayHighCount;
        applyStimulus(24'h000C31, 8'hC1, 1'b1, 1'b0);
        serveFill(24'h000C30, 4, 2, 8'hC0, -1, -1, -1, 1'b0);
        @(negedge Clk);
        checkOutput("backpressure DelayCycles", 32'(delayCycles), 32'd20);
        checkOutput("backpressure Delay cycles seen", 32'(delayHighCount - delayMark), 32'd20);
        checkOutput("Error sticky", 32'(error), 32'd1);

        // Reset during beat 4; the same line must miss again afterwards
        applyStimulus(24'h000D02, 8'h00, 1'b0, 1'b0);
        serveFill(24'h000D00, 0, 1, 8'hD0, -1, 4, -1, 1'b0);
        @(negedge Clk);
        applyStimulus(24'h000D02, 8'hE2, 1'b1, 1'b0);
        serveFill(24'h000D00, 0, 1, 8'hE0, -1, -1, -1, 1'b0);
        @(negedge Clk);
        checkOutput("post-reset DelayCycles", 32'(delayCycles), 32'd9);
        checkOutput("post-reset Error", 32'(error), 32'd0);

        repeat (3) @(negedge Clk);
        checkOutput("responses outstanding", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Absolute time limit in case the DUT wedges the sequence
    initial begin
        #200000;
        $display("[TB] FAIL global timeout: %0d/%0d checks passed", passCount, checkCount);
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/catc_fetch_stall.md
# catc_fetch_stall

Line-buffered read port between a CE-gated retro core and slow backing memory (SDRAM or load image). Core reads that hit the single line buffer are answered before the next core tick. Misses raise `Delay` into the CATC clock-enable generator, which freezes the core and banks the lost reference ticks for later catch-up, while the block bursts the line from memory. It also measures stall length and flags excessive stalls.

## Interface
- `AddrWidth`, 24: core byte address width.
- `DataWidth`, 8: core and memory data width.
- `LineWords`, 8: words per line; power of two, ≥2.
- `MaxDelay`, 4095: stall length in Clk cycles that sets `Error`.

- `Clk` in 1: core clock.
- `Reset` in 1: reset, synchronous, active-high; clock `Clk`.
- `CoreCe` in 1: core tick (CATC `ClkEnOut`).
- `CoreReq` in 1: read request, sampled only when `CoreCe`=1.
- `CoreAddr` in AddrWidth: read address.
- `CoreData` out DataWidth: read data.
- `CoreValid` out 1: one-cycle pulse when `CoreData` is updated.
- `Delay` out 1: stall request to CATC. Registered.
- `MemReq` out 1: burst request.
- `MemAddr` out AddrWidth: line base address, with the low log2(LineWords) bits zero.
- `MemReady` in 1: burst request accepted.
- `MemRdValid` in 1: read beat valid.
- `MemRdData` in DataWidth: read beat data.
- `Flush` in 1: invalidate the line buffer.
- `Error` out 1: sticky; set when a stall reaches `MaxDelay`.
- `DelayCycles` out 16: length of the last stall in Clk cycles. Saturates at 65535.

## Operation
- State: line array `LineWords`×`DataWidth`, tag (AddrWidth−log2 LineWords bits), valid bit. The FSM has four states: IDLE, FILL_REQ, FILL_DATA, DONE.
- **IDLE**
  - The block samples a request on any cycle with `CoreCe` && `CoreReq`.
  - Hit (valid && tag match): `CoreData` ← line[offset], `CoreValid`=1 next cycle. State stays IDLE.
  - Miss: latch the address and go to FILL_REQ.
  - `MemRdValid` is ignored in IDLE.
- **FILL_REQ**
  - `Delay`=1, `MemReq`=1, `MemAddr`=line base.
  - On `MemReq`&&`MemReady`, drop `MemReq`, clear the beat counter, go to FILL_DATA.
- **FILL_DATA**
  - `Delay`=1.
  - Each `MemRdValid` writes line[beat] and increments beat.
  - On beat LineWords−1, go to DONE.
- **DONE** (one cycle)
  - `Delay`=0, `CoreValid`=1, `CoreData`=line[requested offset].
  - Tag ← latched tag. Valid ← 1 unless a flush is pending.
  - `DelayCycles` ← stall count. Return to IDLE.
- **Flush**
  - Flush in IDLE clears valid next cycle.
  - Flush during FILL_REQ/FILL_DATA sets flush-pending. The fill completes and the core still gets its data, but valid ends 0.
  - Flush coincident with a sampled hit: the hit is answered from the old line, and valid clears.
- **Stall counter**
  - Counts every cycle `Delay`=1 and is cleared on entry to FILL_REQ.
  - When the count equals `MaxDelay`, `Error` ← 1 (sticky until Reset). The fill continues unaltered.
- A `CoreCe`&&`CoreReq` outside IDLE is ignored; CATC suppresses CE while `Delay`=1.
- `Delay` is never combinational from `CoreCe`; CATC gates CE with `Delay`, so a combinational path would form a loop.

## Timing
- **Reset values:** FSM=IDLE. `Delay`=0, `MemReq`=0, `CoreValid`=0, `CoreData`=0, `Error`=0, `DelayCycles`=0, `MemAddr`=0, valid=0.
- **Reset mid-fill:** the next cycle is IDLE with `Delay`=0. Late beats are ignored.
- **Hit:** request sampled at T → `CoreValid`/`CoreData` at T+1. `CoreData` holds until the next update.
- **Miss:**
  - Sampled at T; `Delay`=1 and `MemReq`=1 from T+1.
  - Last beat at L → DONE at L+1 with `Delay`=0 and `CoreValid`=1.
  - `Delay` is high T+1..L inclusive, so `DelayCycles`=L−T.
  - Minimum case: `MemReady` at T+1, beats T+2..T+1+LineWords, `CoreValid` at T+2+LineWords, `DelayCycles`=LineWords+1.
- **CoreCe spacing:** requires CoreCe pulses ≥2 Clk apart. The registered `Delay` then lands before the next CE.
- **Back-to-back requests:** a request may be sampled in the cycle after DONE.

## Test plan
- **Cold miss then hit:** Reset, then read 0x000123 with `MemReady` immediate and beats 0x10..0x17 on consecutive cycles → `MemAddr`=0x000120; `Delay` high 9 cycles; `CoreData`=0x13; `DelayCycles`=9. A following read of 0x000125 gives a 1-cycle response 0x15 with `Delay` never high.
- **Backpressure/gaps:** `MemReady` delayed 5 cycles, 2-cycle gap between each beat → `Delay` held throughout, `DelayCycles`=20, data correct.
- **Flush during fill:** Flush at beat 3 → the miss still returns the correct word. A re-read of the same line misses again (`MemReq` reasserts).
- **Watchdog:** `MaxDelay`=16, `MemReady` withheld 20 cycles → `Error` rises on the 16th `Delay` cycle and stays 1 after the fill completes and after further clean misses. It clears only on Reset.
- **Reset mid-fill:** Reset during beat 4 → next cycle `Delay`=0 and `MemReq`=0. The remaining beats are ignored. The next read of the same line misses.
- **Ignored request during stall:** force `CoreCe`&&`CoreReq` while `Delay`=1 with a different address → no effect on `MemAddr`, the fill, or `CoreData`.
